hud_score_ctrl: RTL and testbench

- Game-side controller that owns the HUD score and lives values and sequences all writes into the HUD text RAM (8-bit address, 8-bit ASCII data, one write port).
- Keeps the score as 4 BCD digits and lives as one BCD digit. It adds BCD point awards digit-serially and rewrites the ASCII digit cells whenever a value changes.
- Sits between game logic (pellet, ghost and death events) and the text RAM write port. The VGA text path owns the RAM read port.

---
 rtl/hud_score_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_hud_score_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hud_score_ctrl.sv
// ---------------------------------------------------------------------------
// hud_score_ctrl
//
// Keeps the HUD score (4 BCD digits) and lives (1 BCD digit) and sequences
// every write into the HUD text RAM. Point awards are added one digit per
// cycle, LSD first. The five ASCII digit cells are rewritten whenever either
// value changes.
//
// Ports
//   Clk        system clock, rising edge
//   Reset_n    asynchronous active-low reset
//   pts_valid  point award presented
//   pts_bcd    award, 4 BCD digits, [15:12] is the MSD
//   pts_ready  award can be accepted this cycle
//   life_dec   pulse: lose one life
//   life_inc   pulse: gain one life
//   clear      pulse: start a new game (aborts any operation)
//   ram_we     text RAM write enable
//   ram_addr   text RAM write address
//   ram_data   ASCII byte written
//   busy       FSM is not idle
//   score_bcd  current score, BCD
//   lives      current lives, 0-9
//   game_over  lives reached 0 through a decrement
// ---------------------------------------------------------------------------
module hud_score_ctrl #(
    parameter logic [7:0] SCORE_ADDR = 8'd7,
    parameter logic [7:0] LIVES_ADDR = 8'd32,
    parameter logic [3:0] INIT_LIVES = 4'd2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pts_valid,
    input  logic [15:0] pts_bcd,
    output logic        pts_ready,
    input  logic        life_dec,
    input  logic        life_inc,
    input  logic        clear,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_data,
    output logic        busy,
    output logic [15:0] score_bcd,
    output logic [3:0]  lives,
    output logic        game_over
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] award;
    logic [1:0]  digit_idx;
    logic        carry;
    logic [2:0]  wr_idx;
    logic        pend_inc;
    logic        pend_dec;

    // Any digit above 9 in an incoming award is treated as 9.
    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Address/data of write number idx of a HUD refresh: four score cells
    // MSD first, then the lives cell.
    function automatic logic [15:0] cell_write(input logic [2:0]  idx,
                                               input logic [15:0] sc,
                                               input logic [3:0]  lv);
        logic [15:0] r;
        case (idx)
            3'd0:    r = {SCORE_ADDR,         8'h30 + {4'h0, sc[15:12]}};
            3'd1:    r = {SCORE_ADDR + 8'd1,  8'h30 + {4'h0, sc[11:8]}};
            3'd2:    r = {SCORE_ADDR + 8'd2,  8'h30 + {4'h0, sc[7:4]}};
            3'd3:    r = {SCORE_ADDR + 8'd3,  8'h30 + {4'h0, sc[3:0]}};
            default: r = {LIVES_ADDR,         8'h30 + {4'h0, lv}};
        endcase
        return r;
    endfunction

    assign pts_ready = (state == IDLE) && !pend_inc && !pend_dec && !clear;
    assign busy      = (state != IDLE);

    // Life events seen in IDLE merge any pending flags with new pulses; an
    // inc and a dec together cancel. Saturates at 0 and 9.
    logic       eff_inc;
    logic       eff_dec;
    logic [3:0] lives_next;
    logic       go_next;
    logic       life_changed;

    always_comb begin
        eff_inc      = pend_inc | life_inc;
        eff_dec      = pend_dec | life_dec;
        lives_next   = lives;
        go_next      = game_over;
        life_changed = 1'b0;
        if (eff_inc && !eff_dec && (lives < 4'd9)) begin
            lives_next   = lives + 4'd1;
            life_changed = 1'b1;
        end else if (eff_dec && !eff_inc && (lives != 4'd0)) begin
            lives_next   = lives - 4'd1;
            life_changed = 1'b1;
            if (lives == 4'd1) go_next = 1'b1;
        end
    end

    // While busy, life pulses collapse into one flag per kind; a flag of each
    // kind cancels both.
    logic p_inc;
    logic p_dec;

    always_comb begin
        p_inc = pend_inc | life_inc;
        p_dec = pend_dec | life_dec;
        if (p_inc && p_dec) begin
            p_inc = 1'b0;
            p_dec = 1'b0;
        end
    end

    // One BCD digit of the award addition. On the last digit a carry out
    // saturates the whole score to 9999.
    logic [3:0]  s_dig;
    logic [3:0]  p_dig;
    logic [4:0]  sum;
    logic [4:0]  sum_adj;
    logic [3:0]  dig_out;
    logic        carry_out;
    logic [15:0] add_score;

    always_comb begin
        s_dig = 4'd0;
        p_dig = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (digit_idx == 2'(i)) begin
                s_dig = score_bcd[i*4 +: 4];
                p_dig = award[i*4 +: 4];
            end
        end
        sum       = {1'b0, s_dig} + {1'b0, p_dig} + {4'b0, carry};
        sum_adj   = sum - 5'd10;
        carry_out = (sum > 5'd9);
        dig_out   = carry_out ? sum_adj[3:0] : sum[3:0];
        add_score = score_bcd;
        for (int i = 0; i < 4; i++) begin
            if (digit_idx == 2'(i)) add_score[i*4 +: 4] = dig_out;
        end
        if ((digit_idx == 2'd3) && carry_out) add_score = 16'h9999;
    end

    // Main FSM. The first RAM write of a refresh is presented on the edge
    // that enters WRITE, using the values being stored on that same edge, so
    // the five writes land on the five edges that follow.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            score_bcd <= 16'h0000;
            lives     <= INIT_LIVES;
            game_over <= 1'b0;
            award     <= 16'h0000;
            digit_idx <= 2'd0;
            carry     <= 1'b0;
            wr_idx    <= 3'd0;
            pend_inc  <= 1'b0;
            pend_dec  <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 8'h00;
            ram_data  <= 8'h00;
        end else if (clear) begin
            state                <= WRITE;
            score_bcd            <= 16'h0000;
            lives                <= INIT_LIVES;
            game_over            <= 1'b0;
            award                <= 16'h0000;
            digit_idx            <= 2'd0;
            carry                <= 1'b0;
            wr_idx               <= 3'd0;
            pend_inc             <= 1'b0;
            pend_dec             <= 1'b0;
            ram_we               <= 1'b1;
            {ram_addr, ram_data} <= cell_write(3'd0, 16'h0000, INIT_LIVES);
        end else begin
            case (state)
                IDLE: begin
                    pend_inc  <= 1'b0;
                    pend_dec  <= 1'b0;
                    lives     <= lives_next;
                    game_over <= go_next;
                    if (pts_valid && pts_ready) begin
                        award     <= clamp_bcd(pts_bcd);
                        digit_idx <= 2'd0;
                        carry     <= 1'b0;
                        state     <= ADD;
                    end else if (life_changed) begin
                        state                <= WRITE;
                        wr_idx               <= 3'd0;
                        ram_we               <= 1'b1;
                        {ram_addr, ram_data} <= cell_write(3'd0, score_bcd, lives_next);
                    end
                end
                ADD: begin
                    pend_inc  <= p_inc;
                    pend_dec  <= p_dec;
                    score_bcd <= add_score;
                    carry     <= carry_out;
                    digit_idx <= digit_idx + 2'd1;
                    if (digit_idx == 2'd3) begin
                        state                <= WRITE;
                        wr_idx               <= 3'd0;
                        ram_we               <= 1'b1;
                        {ram_addr, ram_data} <= cell_write(3'd0, add_score, lives);
                    end
                end
                WRITE: begin
                    pend_inc <= p_inc;
                    pend_dec <= p_dec;
                    if (wr_idx == 3'd4) begin
                        ram_we <= 1'b0;
                        wr_idx <= 3'd0;
                        state  <= IDLE;
                    end else begin
                        wr_idx               <= wr_idx + 3'd1;
                        {ram_addr, ram_data} <= cell_write(wr_idx + 3'd1, score_bcd, lives);
                    end
                end
                default: begin
                    state  <= IDLE;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hud_score_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for hud_score_ctrl: a table of cumulative point awards, each
// checked for final score, ready-low duration and the exact RAM write
// sequence, followed by hand-written life, pending-event and clear sequences.
// ---------------------------------------------------------------------------
module tb_hud_score_ctrl;

    localparam logic [7:0] SCORE_ADDR = 8'd7;
    localparam logic [7:0] LIVES_ADDR = 8'd32;
    localparam logic [3:0] INIT_LIVES = 4'd2;

    logic        Clk;
    logic        Reset_n;
    logic        pts_valid;
    logic [15:0] pts_bcd;
    logic        pts_ready;
    logic        life_dec;
    logic        life_inc;
    logic        clear;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        busy;
    logic [15:0] score_bcd;
    logic [3:0]  lives;
    logic        game_over;

    hud_score_ctrl #(
        .SCORE_ADDR (SCORE_ADDR),
        .LIVES_ADDR (LIVES_ADDR),
        .INIT_LIVES (INIT_LIVES)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .pts_valid (pts_valid),
        .pts_bcd   (pts_bcd),
        .pts_ready (pts_ready),
        .life_dec  (life_dec),
        .life_inc  (life_inc),
        .clear     (clear),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .busy      (busy),
        .score_bcd (score_bcd),
        .lives     (lives),
        .game_over (game_over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        do_clear;
        logic [15:0] pts;
        logic [15:0] exp_score;
    } vec_t;

    typedef struct {
        int         edge_n;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    vec_t vecs[8];
    wr_t  wlog[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Posedge counter; edge number cyc+1 is the next rising edge.
    always @(posedge Clk) cyc <= cyc + 1;

    // A write presented now is captured by the RAM on the next rising edge.
    always @(negedge Clk) begin
        if (Reset_n && ram_we) wlog.push_back('{cyc + 1, ram_addr, ram_data});
    end

    task automatic checkOutput(input string name, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Compare the five writes of one HUD refresh starting at wlog[base].
    task automatic checkWrites(input int base, input logic [15:0] sc,
                               input logic [3:0] lv, input int first_edge);
        logic [7:0] ea;
        logic [7:0] ed;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                ea = SCORE_ADDR + 8'(i);
                ed = 8'h30 + {4'h0, sc[(3-i)*4 +: 4]};
            end else begin
                ea = LIVES_ADDR;
                ed = 8'h30 + {4'h0, lv};
            end
            if (base + i < wlog.size()) begin
                checkOutput($sformatf("wr%0d_addr", base + i), wlog[base+i].addr, ea);
                checkOutput($sformatf("wr%0d_data", base + i), wlog[base+i].data, ed);
                checkOutput($sformatf("wr%0d_edge", base + i), wlog[base+i].edge_n, first_edge + i);
            end else begin
                checkOutput($sformatf("wr%0d_present", base + i), 0, 1);
            end
        end
    endtask

    task automatic acceptAward(input logic [15:0] pts, output int t_edge);
        int n;
        n = 0;
        @(negedge Clk);
        while (!pts_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        checkOutput("ready_timeout", int'(pts_ready), 1);
        pts_valid = 1'b1;
        pts_bcd   = pts;
        t_edge    = cyc + 1;
        @(posedge Clk);
        #1;
        pts_valid = 1'b0;
        pts_bcd   = 16'h0000;
    endtask

    task automatic pulseLife(input logic inc, input logic dec, output int p_edge);
        @(negedge Clk);
        life_inc = inc;
        life_dec = dec;
        p_edge   = cyc + 1;
        @(posedge Clk);
        #1;
        life_inc = 1'b0;
        life_dec = 1'b0;
        repeat (12) @(negedge Clk);
    endtask

    task automatic clearGame();
        int c_edge;
        wlog.delete();
        @(negedge Clk);
        clear  = 1'b1;
        c_edge = cyc + 1;
        @(posedge Clk);
        #1;
        clear = 1'b0;
        repeat (10) @(negedge Clk);
        checkOutput("clear_nwr", wlog.size(), 5);
        checkWrites(0, 16'h0000, INIT_LIVES, c_edge + 1);
        checkOutput("clear_score", score_bcd, 16'h0000);
        checkOutput("clear_lives", lives, INIT_LIVES);
        checkOutput("clear_go", game_over, 0);
    endtask

    // One table row: optional new game, then an award checked end to end.
    task automatic applyStimulus(input vec_t v);
        int t_edge;
        int lowc;
        if (v.do_clear) clearGame();
        wlog.delete();
        acceptAward(v.pts, t_edge);
        lowc = 0;
        @(negedge Clk);
        while (!pts_ready && lowc < 40) begin
            lowc++;
            @(negedge Clk);
        end
        checkOutput("ready_low_cycles", lowc, 9);
        checkOutput("award_score", score_bcd, v.exp_score);
        checkOutput("award_nwr", wlog.size(), 5);
        checkWrites(0, v.exp_score, lives, t_edge + 5);
    endtask

    initial begin
        int p_edge;
        int t_edge;

        vecs[0] = '{1'b0, 16'h0010, 16'h0010};
        vecs[1] = '{1'b0, 16'h0985, 16'h0995};
        vecs[2] = '{1'b0, 16'h0005, 16'h1000};
        vecs[3] = '{1'b0, 16'h8990, 16'h9990};
        vecs[4] = '{1'b0, 16'h0050, 16'h9999};
        vecs[5] = '{1'b0, 16'h0001, 16'h9999};
        vecs[6] = '{1'b1, 16'h00AF, 16'h0099};
        vecs[7] = '{1'b0, 16'h0001, 16'h0100};

        Reset_n   = 1'b0;
        pts_valid = 1'b0;
        pts_bcd   = 16'h0000;
        life_dec  = 1'b0;
        life_inc  = 1'b0;
        clear     = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        checkOutput("rst_score", score_bcd, 16'h0000);
        checkOutput("rst_lives", lives, INIT_LIVES);
        checkOutput("rst_go", game_over, 0);
        checkOutput("rst_we", ram_we, 0);
        checkOutput("rst_addr", ram_addr, 0);
        checkOutput("rst_data", ram_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", pts_ready, 1);
        checkOutput("rst_nwr", wlog.size(), 0);

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Lives down to zero, then saturate, then inc keeps game_over.
        wlog.delete();
        pulseLife(1'b0, 1'b1, p_edge);
        checkOutput("dec1_lives", lives, 1);
        checkOutput("dec1_go", game_over, 0);
        checkOutput("dec1_nwr", wlog.size(), 5);
        checkWrites(0, 16'h0100, 4'd1, p_edge + 1);
        wlog.delete();
        pulseLife(1'b0, 1'b1, p_edge);
        checkOutput("dec2_lives", lives, 0);
        checkOutput("dec2_go", game_over, 1);
        checkOutput("dec2_nwr", wlog.size(), 5);
        checkWrites(0, 16'h0100, 4'd0, p_edge + 1);
        wlog.delete();
        pulseLife(1'b0, 1'b1, p_edge);
        checkOutput("dec3_lives", lives, 0);
        checkOutput("dec3_nwr", wlog.size(), 0);
        wlog.delete();
        pulseLife(1'b1, 1'b0, p_edge);
        checkOutput("inc_lives", lives, 1);
        checkOutput("inc_go", game_over, 1);
        checkOutput("inc_nwr", wlog.size(), 5);

        // life_dec during ADD is held until the award refresh finishes.
        clearGame();
        wlog.delete();
        acceptAward(16'h0001, t_edge);
        @(negedge Clk);
        @(negedge Clk);
        life_dec = 1'b1;
        @(posedge Clk);
        #1;
        life_dec = 1'b0;
        repeat (25) @(negedge Clk);
        checkOutput("pend_nwr", wlog.size(), 10);
        checkWrites(0, 16'h0001, INIT_LIVES, t_edge + 5);
        checkWrites(5, 16'h0001, INIT_LIVES - 4'd1, t_edge + 11);
        checkOutput("pend_lives", lives, INIT_LIVES - 4'd1);

        // inc and dec together in IDLE cancel.
        wlog.delete();
        pulseLife(1'b1, 1'b1, p_edge);
        checkOutput("cancel_nwr", wlog.size(), 0);
        checkOutput("cancel_lives", lives, INIT_LIVES - 4'd1);

        // clear during the WRITE of 0x1234, with a pending dec to be dropped.
        wlog.delete();
        acceptAward(16'h1234, t_edge);
        @(negedge Clk);
        life_dec = 1'b1;
        @(posedge Clk);
        #1;
        life_dec = 1'b0;
        repeat (6) @(negedge Clk);
        clear = 1'b1;
        @(posedge Clk);
        #1;
        clear = 1'b0;
        repeat (20) @(negedge Clk);
        checkOutput("abort_nwr", wlog.size(), 8);
        for (int i = 0; i < 3; i++) begin
            if (i < wlog.size()) begin
                checkOutput($sformatf("abort_wr%0d_addr", i), wlog[i].addr, SCORE_ADDR + 8'(i));
                checkOutput($sformatf("abort_wr%0d_data", i), wlog[i].data, 8'h31 + 8'(i));
            end
        end
        checkWrites(3, 16'h0000, INIT_LIVES, t_edge + 8);
        checkOutput("abort_score", score_bcd, 16'h0000);
        checkOutput("abort_lives", lives, INIT_LIVES);
        checkOutput("abort_go", game_over, 0);
        checkOutput("abort_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
